// File: rtl/dat_pkg.sv
// Shared definitions for the data-transfer scheduler: FSM state encoding and defaults.
package dat_pkg;

    localparam int BLOCKS_W_DEF   = 4;
    localparam int ABORT_HOLD_DEF = 2;
    localparam int HOLD_CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_BUSY  = 3'd2,
        ST_ACK   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ABORT = 3'd5
    } dat_state_e;

endpackage

// File: rtl/dat_rr_arb2.sv
// Two-requester round-robin selector: on contention the requester other than
// last_owner wins; a lone requester always wins.
module dat_rr_arb2 (
    input  logic       last_owner,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_owner ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dat_xfer_scheduler.sv
// Arbitrates two requesters onto one data phys controller and sequences the transfer.
// Optional timeout abort path enabled by defining DAT_SCHED_TIMEOUT_ABORT_EN.
module dat_xfer_scheduler
    import dat_pkg::*;
#(
    parameter int BLOCKS_W   = BLOCKS_W_DEF,
    parameter int ABORT_HOLD = ABORT_HOLD_DEF
) (
    input  logic                sd_clock,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [1:0]          wr_req,
    input  logic [1:0]          mult_req,
    input  logic [BLOCKS_W-1:0] blocks_req0,
    input  logic [BLOCKS_W-1:0] blocks_req1,
    output logic [1:0]          grant,
    output logic [1:0]          done,
    output logic [1:0]          error,
    output logic                strobe_out,
    output logic                writeRead_out,
    output logic                multiple_out,
    output logic [BLOCKS_W-1:0] blocks_out,
    output logic                ack_out,
    output logic                idle_out,
    input  logic                serial_ready_in,
    input  logic                complete_in,
    input  logic                ack_in,
    input  logic                timeout_in,
    output logic                busy
);

    dat_state_e            state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_owner_q, last_owner_d;
    logic                  wr_q, wr_d;
    logic                  mult_q, mult_d;
    logic [BLOCKS_W-1:0]   blocks_q, blocks_d;
    logic [HOLD_CNT_W-1:0] hold_q, hold_d;

    logic [1:0] arb_grant;
    logic       arb_sel;
    logic       timeout_abort;
    logic       hold_last;

`ifdef DAT_SCHED_TIMEOUT_ABORT_EN
    assign timeout_abort = timeout_in;
`else
    logic unused_timeout;
    assign unused_timeout = timeout_in;
    assign timeout_abort  = 1'b0;
`endif

    dat_rr_arb2 u_arb (
        .last_owner (last_owner_q),
        .req        (req),
        .grant      (arb_grant)
    );

    assign arb_sel   = arb_grant[1];
    assign hold_last = (hold_q == HOLD_CNT_W'(ABORT_HOLD - 1));

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            last_owner_q <= 1'b1;
            wr_q         <= 1'b0;
            mult_q       <= 1'b0;
            blocks_q     <= '0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            wr_q         <= wr_d;
            mult_q       <= mult_d;
            blocks_q     <= blocks_d;
            hold_q       <= hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        wr_d         = wr_q;
        mult_d       = mult_q;
        blocks_d     = blocks_q;
        hold_d       = hold_q;
        case (state_q)
            ST_IDLE: begin
                // Transfer fields are captured only here, so they cannot move while granted.
                if (req != 2'b00) begin
                    grant_d  = arb_grant;
                    wr_d     = wr_req[arb_sel];
                    mult_d   = mult_req[arb_sel];
                    blocks_d = arb_sel ? blocks_req1 : blocks_req0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (timeout_abort) begin
                    hold_d  = '0;
                    state_d = ST_ABORT;
                end else if (serial_ready_in) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Completion wins over a simultaneous timeout.
                if (complete_in) begin
                    state_d = ST_ACK;
                end else if (timeout_abort) begin
                    hold_d  = '0;
                    state_d = ST_ABORT;
                end
            end
            ST_ACK: begin
                if (ack_in) begin
                    state_d = ST_DONE;
                end else if (timeout_abort) begin
                    hold_d  = '0;
                    state_d = ST_ABORT;
                end
            end
            ST_DONE: begin
                last_owner_d = grant_q[1];
                grant_d      = 2'b00;
                state_d      = ST_IDLE;
            end
            ST_ABORT: begin
                if (hold_last) begin
                    last_owner_d = grant_q[1];
                    grant_d      = 2'b00;
                    state_d      = ST_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        strobe_out = (state_q == ST_ISSUE) && serial_ready_in && !timeout_abort;
        ack_out    = (state_q == ST_ACK);
        done       = (state_q == ST_DONE) ? grant_q : 2'b00;
        busy       = (state_q != ST_IDLE);
`ifdef DAT_SCHED_TIMEOUT_ABORT_EN
        idle_out   = (state_q == ST_ABORT);
        error      = ((state_q == ST_ABORT) && hold_last) ? grant_q : 2'b00;
`else
        idle_out   = 1'b0;
        error      = 2'b00;
`endif
    end

    assign grant         = grant_q;
    assign writeRead_out = wr_q;
    assign multiple_out  = mult_q;
    assign blocks_out    = blocks_q;

endmodule

// File: tb/tb_dat_xfer_scheduler.sv
// Randomized transaction-level bench for dat_xfer_scheduler; expectations come from
// a round-robin ownership model and the per-phase protocol rules.
module tb_dat_xfer_scheduler;

    localparam int BW    = 4;
    localparam int AHOLD = 2;

    logic          sd_clock = 1'b0;
    logic          reset;
    logic [1:0]    req, wr_req, mult_req;
    logic [BW-1:0] blocks_req0, blocks_req1;
    logic [1:0]    grant, done, error;
    logic          strobe_out, writeRead_out, multiple_out, ack_out, idle_out, busy;
    logic [BW-1:0] blocks_out;
    logic          serial_ready_in, complete_in, ack_in, timeout_in;

    int n_checks = 0;
    int n_fail   = 0;
    int last_owner_m = 1;

    always #5 sd_clock = ~sd_clock;

    dat_xfer_scheduler #(.BLOCKS_W(BW), .ABORT_HOLD(AHOLD)) dut (
        .sd_clock        (sd_clock),
        .reset           (reset),
        .req             (req),
        .wr_req          (wr_req),
        .mult_req        (mult_req),
        .blocks_req0     (blocks_req0),
        .blocks_req1     (blocks_req1),
        .grant           (grant),
        .done            (done),
        .error           (error),
        .strobe_out      (strobe_out),
        .writeRead_out   (writeRead_out),
        .multiple_out    (multiple_out),
        .blocks_out      (blocks_out),
        .ack_out         (ack_out),
        .idle_out        (idle_out),
        .serial_ready_in (serial_ready_in),
        .complete_in     (complete_in),
        .ack_in          (ack_in),
        .timeout_in      (timeout_in),
        .busy            (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge sd_clock);
        #1;
    endtask

    task automatic smp();
        @(negedge sd_clock);
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_grant"}, grant, 0);
        check_eq({pfx, "_done"}, done, 0);
        check_eq({pfx, "_error"}, error, 0);
        check_eq({pfx, "_strobe"}, strobe_out, 0);
        check_eq({pfx, "_ack"}, ack_out, 0);
        check_eq({pfx, "_idle"}, idle_out, 0);
        check_eq({pfx, "_busy"}, busy, 0);
        check_eq({pfx, "_blocks"}, blocks_out, 0);
        check_eq({pfx, "_wr"}, writeRead_out, 0);
        check_eq({pfx, "_mult"}, multiple_out, 0);
    endtask

    task automatic check_fields(input logic [1:0] g, input logic w, input logic m, input logic [BW-1:0] b);
        check_eq("grant", grant, g);
        check_eq("wr_out", writeRead_out, w);
        check_eq("mult_out", multiple_out, m);
        check_eq("blocks_out", blocks_out, b);
    endtask

    // Called at posedge+1 of the cycle timeout_in was raised; ends at posedge+1 of an IDLE cycle.
    task automatic abort_seq(input int owner, input logic [1:0] g);
        req = 2'b00;
        smp();
        check_eq("pre_abort_idle", idle_out, 0);
        nxt();
        timeout_in = 1'b0;
        for (int h = 0; h < AHOLD; h++) begin
            smp();
            check_eq("abort_idle_out", idle_out, 1);
            check_eq("abort_error", error, (h == AHOLD - 1) ? g : 2'b00);
            check_eq("abort_no_done", done, 0);
            check_eq("abort_grant", grant, g);
            nxt();
        end
        smp();
        check_eq("post_abort_grant", grant, 0);
        check_eq("post_abort_idle", idle_out, 0);
        check_eq("post_abort_error", error, 0);
        last_owner_m = owner;
        nxt();
    endtask

    // tmode: 0 normal, 1 timeout in BUSY, 2 timeout in ACK. Starts and ends at posedge+1 in IDLE.
    task automatic run_xfer(input int tmode, input logic [1:0] pat_in);
        logic [1:0]    pat, exp_g;
        logic          exp_wr, exp_mult;
        logic [BW-1:0] exp_blk;
        int            owner;
        pat = (pat_in != 2'b00) ? pat_in : 2'($urandom_range(1, 3));
        req = pat;
        wr_req = 2'($urandom);
        mult_req = 2'($urandom);
        blocks_req0 = BW'($urandom);
        blocks_req1 = BW'($urandom);
        serial_ready_in = 1'b0;
        complete_in = 1'b0;
        ack_in = 1'b0;
        timeout_in = 1'b0;
        if (pat == 2'b11) owner = (last_owner_m == 1) ? 0 : 1;
        else              owner = pat[1] ? 1 : 0;
        exp_g    = owner ? 2'b10 : 2'b01;
        exp_wr   = wr_req[owner];
        exp_mult = mult_req[owner];
        exp_blk  = owner ? blocks_req1 : blocks_req0;
        smp();
        check_eq("idle_grant", grant, 0);
        nxt();
        // Requesters change their minds; the granted transfer must not notice.
        req = 2'($urandom);
        wr_req = 2'($urandom);
        mult_req = 2'($urandom);
        blocks_req0 = BW'($urandom);
        blocks_req1 = BW'($urandom);
        repeat ($urandom_range(0, 5)) begin
            smp();
            check_eq("strobe_backpressure", strobe_out, 0);
            check_fields(exp_g, exp_wr, exp_mult, exp_blk);
            nxt();
        end
        serial_ready_in = 1'b1;
        smp();
        check_eq("strobe_pulse", strobe_out, 1);
        check_fields(exp_g, exp_wr, exp_mult, exp_blk);
        nxt();
        serial_ready_in = 1'($urandom);
        repeat ($urandom_range(1, 3)) begin
            smp();
            check_eq("strobe_single", strobe_out, 0);
            check_eq("busy_no_ack", ack_out, 0);
            check_eq("busy_flag", busy, 1);
            nxt();
        end
        if (tmode == 1) begin
            timeout_in = 1'b1;
`ifdef DAT_SCHED_TIMEOUT_ABORT_EN
            abort_seq(owner, exp_g);
            return;
`else
            repeat (2) begin
                smp();
                check_eq("to_ign_ack", ack_out, 0);
                check_eq("to_ign_idle", idle_out, 0);
                check_eq("to_ign_error", error, 0);
                check_eq("to_ign_busy", busy, 1);
                nxt();
            end
            timeout_in = 1'b0;
`endif
        end
        complete_in = 1'b1;
        timeout_in = 1'($urandom_range(0, 1));
        smp();
        check_eq("complete_cycle_ack", ack_out, 0);
        nxt();
        complete_in = 1'b0;
        timeout_in = 1'b0;
        repeat ($urandom_range(0, 3)) begin
            smp();
            check_eq("ack_wait", ack_out, 1);
            check_eq("ack_no_done", done, 0);
            nxt();
        end
        if (tmode == 2) begin
            timeout_in = 1'b1;
`ifdef DAT_SCHED_TIMEOUT_ABORT_EN
            abort_seq(owner, exp_g);
            return;
`else
            repeat (2) begin
                smp();
                check_eq("to_ign_ack_hold", ack_out, 1);
                check_eq("to_ign_idle2", idle_out, 0);
                nxt();
            end
            timeout_in = 1'b0;
`endif
        end
        ack_in = 1'b1;
        smp();
        check_eq("ack_seen", ack_out, 1);
        nxt();
        ack_in = 1'b0;
        req = 2'b00;
        smp();
        check_eq("done_pulse", done, exp_g);
        check_eq("done_no_error", error, 0);
        check_fields(exp_g, exp_wr, exp_mult, exp_blk);
        last_owner_m = owner;
        nxt();
        smp();
        check_eq("done_cleared", done, 0);
        check_eq("grant_cleared", grant, 0);
        check_eq("idle_busy", busy, 0);
        nxt();
    endtask

    task automatic reset_in_ack();
        req = 2'b10;
        wr_req = 2'b11;
        mult_req = 2'b10;
        blocks_req1 = BW'(5);
        serial_ready_in = 1'b1;
        complete_in = 1'b0;
        ack_in = 1'b0;
        timeout_in = 1'b0;
        nxt();
        nxt();
        complete_in = 1'b1;
        nxt();
        complete_in = 1'b0;
        #2;
        check_eq("rst_pre_ack", ack_out, 1);
        check_eq("rst_pre_grant", grant, 2'b10);
        reset = 1'b1;
        #1;
        check_all_zero("rst_async");
        req = 2'b00;
        serial_ready_in = 1'b0;
        nxt();
        nxt();
        reset = 1'b0;
        last_owner_m = 1;
        repeat (2) begin
            smp();
            check_eq("rst_no_done", done, 0);
            check_eq("rst_no_error", error, 0);
            nxt();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req = 2'b00;
        wr_req = 2'b00;
        mult_req = 2'b00;
        blocks_req0 = '0;
        blocks_req1 = '0;
        serial_ready_in = 1'b0;
        complete_in = 1'b0;
        ack_in = 1'b0;
        timeout_in = 1'b0;
        repeat (3) nxt();
        smp();
        check_all_zero("reset");
        nxt();
        reset = 1'b0;
        run_xfer(0, 2'b11);
        run_xfer(0, 2'b11);
        for (int i = 0; i < 30; i++) begin
            run_xfer($urandom_range(0, 2), 2'b00);
        end
        run_xfer(1, 2'b10);
        run_xfer(2, 2'b01);
        run_xfer(0, 2'b01);
        reset_in_ack();
        run_xfer(0, 2'b11);
        run_xfer(0, 2'b10);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
